// File: rtl/dt_sample_ctrl_if.sv
// Estimator-side bus of the dT sample sequencer.
// The master drives sample/config/strobes; the slave returns dT.
interface dt_sample_ctrl_if;
    logic signed [7:0] est_T;
    logic [7:0]        est_alpha;
    logic [7:0]        est_k;
    logic [7:0]        est_dmax;
    logic              est_init;
    logic              est_en;
    logic signed [7:0] est_dT;
    logic              est_valid;

    modport master (
        output est_T,
        output est_alpha,
        output est_k,
        output est_dmax,
        output est_init,
        output est_en,
        input  est_dT,
        input  est_valid
    );

    modport slave (
        input  est_T,
        input  est_alpha,
        input  est_k,
        input  est_dmax,
        input  est_init,
        input  est_en,
        output est_dT,
        output est_valid
    );
endinterface

// File: rtl/dt_sample_ctrl.sv
// Sample sequencer ahead of the dT estimator: tick divider, INIT/advance
// strobes, config shadowing, warm-up gating and missing-sample fault.
module dt_sample_ctrl #(
    parameter int         PER_W     = 16,
    parameter int         WARM_N    = 4,
    parameter int         MISS_MAX  = 3,
    parameter logic [7:0] RST_ALPHA = 8'd32,
    parameter logic [7:0] RST_K     = 8'd3,
    parameter logic [7:0] RST_DMAX  = 8'd64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              t_valid,
    input  logic signed [7:0] t_in,
    input  logic [PER_W-1:0]  period,
    input  logic              cfg_we,
    input  logic [7:0]        cfg_alpha,
    input  logic [7:0]        cfg_k,
    input  logic [7:0]        cfg_dmax,
    dt_sample_ctrl_if.master  est,
    output logic signed [7:0] dT_out,
    output logic              dT_upd,
    output logic              dT_ready,
    output logic              fault,
    output logic [2:0]        state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT_S = 3'd1;
    localparam logic [2:0] S_WARM   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    localparam logic [7:0] WARM_L = 8'(WARM_N);
    localparam logic [7:0] MISS_L = 8'(MISS_MAX);

    logic [2:0]        state_q, state_d;
    logic [PER_W-1:0]  cnt_q, cnt_d;
    logic signed [7:0] t_lat_q, t_lat_d;
    logic              new_q, new_d;
    logic              pend_q, pend_d;
    logic [7:0]        pa_q, pa_d;
    logic [7:0]        pk_q, pk_d;
    logic [7:0]        pd_q, pd_d;
    logic [7:0]        alpha_q, alpha_d;
    logic [7:0]        k_q, k_d;
    logic [7:0]        dmax_q, dmax_d;
    logic signed [7:0] est_t_q, est_t_d;
    logic              cap_q, cap_d;
    logic [7:0]        warm_q, warm_d;
    logic [7:0]        miss_q, miss_d;
    logic signed [7:0] dt_q, dt_d;
    logic              upd_q, upd_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;

    logic [PER_W-1:0]  per_m1;
    logic              tick;
    logic              fresh;
    logic signed [7:0] smp;
    logic              active;
    logic              cfg_tick;
    logic              good;
    logic              miss;
    logic              miss_hit;
    logic              do_init;
    logic              do_en;
    logic              leave;
    logic              cap_ok;
    logic [7:0]        warm_inc;

    // Tick qualification; a config-apply tick neither strobes nor consumes
    always_comb begin
        per_m1   = (period == '0) ? '0 : period - PER_W'(1);
        tick     = enable && (state_q != S_IDLE) && (cnt_q >= per_m1);
        fresh    = t_valid || new_q;
        smp      = t_valid ? t_in : t_lat_q;
        active   = (state_q == S_WARM) || (state_q == S_RUN);
        cfg_tick = tick && pend_q;
        good     = tick && !pend_q && fresh;
        miss     = tick && !pend_q && !fresh && (state_q != S_FAULT);
        miss_hit = miss && ((miss_q + 8'd1) >= MISS_L);
        do_init  = good && ((state_q == S_WAIT_S) || (state_q == S_FAULT));
        do_en    = good && active;
        leave    = !enable || (cfg_tick && active) || miss_hit;
        cap_ok   = cap_q && est.est_valid && active && !leave;
        warm_inc = warm_q + 8'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + PER_W'(1);
        t_lat_d = t_valid ? t_in : t_lat_q;
        new_d   = good ? 1'b0 : (t_valid || new_q);
        pend_d  = pend_q;
        pa_d    = pa_q;
        pk_d    = pk_q;
        pd_d    = pd_q;
        alpha_d = alpha_q;
        k_d     = k_q;
        dmax_d  = dmax_q;
        est_t_d = (do_init || do_en) ? smp : est_t_q;
        cap_d   = do_en;
        warm_d  = warm_q;
        miss_d  = miss_q;
        dt_d    = dt_q;
        upd_d   = 1'b0;
        ready_d = ready_q;
        fault_d = fault_q;

        if (cap_ok) begin
            dt_d  = est.est_dT;
            upd_d = ready_q;
            if (state_q == S_WARM) begin
                warm_d = warm_inc;
                if (warm_inc >= WARM_L) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end
            end
        end

        if (cfg_tick) begin
            alpha_d = pa_q;
            k_d     = pk_q;
            dmax_d  = pd_q;
            pend_d  = 1'b0;
            if (active) begin
                state_d = S_WAIT_S;
                ready_d = 1'b0;
                warm_d  = '0;
                cap_d   = 1'b0;
            end
        end

        if (do_init) begin
            state_d = S_WARM;
            warm_d  = '0;
            miss_d  = '0;
            fault_d = 1'b0;
        end

        if (do_en) begin
            miss_d = '0;
        end

        if (miss) begin
            miss_d = miss_q + 8'd1;
            if (miss_hit) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
                ready_d = 1'b0;
                warm_d  = '0;
                cap_d   = 1'b0;
            end
        end

        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (enable) begin
                state_d = S_WAIT_S;
            end
        end

        // Run control overrides everything except the config shadow
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            cap_d   = 1'b0;
            warm_d  = '0;
            miss_d  = '0;
            ready_d = 1'b0;
            fault_d = 1'b0;
            upd_d   = 1'b0;
        end

        if (cfg_we) begin
            pa_d   = cfg_alpha;
            pk_d   = cfg_k;
            pd_d   = cfg_dmax;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            t_lat_q <= '0;
            new_q   <= 1'b0;
            pend_q  <= 1'b0;
            pa_q    <= RST_ALPHA;
            pk_q    <= RST_K;
            pd_q    <= RST_DMAX;
            alpha_q <= RST_ALPHA;
            k_q     <= RST_K;
            dmax_q  <= RST_DMAX;
            est_t_q <= '0;
            cap_q   <= 1'b0;
            warm_q  <= '0;
            miss_q  <= '0;
            dt_q    <= '0;
            upd_q   <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_lat_q <= t_lat_d;
            new_q   <= new_d;
            pend_q  <= pend_d;
            pa_q    <= pa_d;
            pk_q    <= pk_d;
            pd_q    <= pd_d;
            alpha_q <= alpha_d;
            k_q     <= k_d;
            dmax_q  <= dmax_d;
            est_t_q <= est_t_d;
            cap_q   <= cap_d;
            warm_q  <= warm_d;
            miss_q  <= miss_d;
            dt_q    <= dt_d;
            upd_q   <= upd_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    assign est.est_T     = est_t_d;
    assign est.est_alpha = alpha_q;
    assign est.est_k     = k_q;
    assign est.est_dmax  = dmax_q;
    assign est.est_init  = do_init;
    assign est.est_en    = do_en;

    assign dT_out   = dt_q;
    assign dT_upd   = upd_q;
    assign dT_ready = ready_q;
    assign fault    = fault_q;
    assign state    = state_q;

endmodule

// File: tb/tb_dt_sample_ctrl.sv
// Scoreboard bench for dt_sample_ctrl: expected strobes and dT updates are
// queued by the stimulus and popped by an independent monitor.
module tb_dt_sample_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              t_valid;
    logic signed [7:0] t_in;
    logic [15:0]       period;
    logic              cfg_we;
    logic [7:0]        cfg_alpha;
    logic [7:0]        cfg_k;
    logic [7:0]        cfg_dmax;
    logic signed [7:0] dT_out;
    logic              dT_upd;
    logic              dT_ready;
    logic              fault;
    logic [2:0]        state;

    dt_sample_ctrl_if est_if ();

    dt_sample_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .t_valid  (t_valid),
        .t_in     (t_in),
        .period   (period),
        .cfg_we   (cfg_we),
        .cfg_alpha(cfg_alpha),
        .cfg_k    (cfg_k),
        .cfg_dmax (cfg_dmax),
        .est      (est_if),
        .dT_out   (dT_out),
        .dT_upd   (dT_upd),
        .dT_ready (dT_ready),
        .fault    (fault),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              init;
        logic signed [7:0] t;
    } strobe_t;

    strobe_t           sq[$];
    logic signed [7:0] uq[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;
    int                last_en = 0;
    logic signed [7:0] stub_val = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_s(input logic init, input logic signed [7:0] t);
        strobe_t s;
        s.init = init;
        s.t    = t;
        sq.push_back(s);
    endtask

    // One tick period with a sample placed two cycles ahead of the tick
    task automatic iter(input logic signed [7:0] v);
        t_valid = 1'b1;
        t_in    = v;
        step(1);
        t_valid = 1'b0;
        step(3);
    endtask

    // Stub estimator: answers one cycle after each advance strobe
    initial begin
        logic en_prev;
        en_prev          = 1'b0;
        est_if.est_valid = 1'b0;
        est_if.est_dT    = '0;
        forever begin
            @(negedge clk);
            est_if.est_valid = en_prev;
            est_if.est_dT    = en_prev ? stub_val : 8'sh55;
            en_prev          = est_if.est_en;
        end
    end

    // Monitor
    initial begin
        strobe_t           s;
        logic signed [7:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (est_if.est_init || est_if.est_en) begin
                    if (est_if.est_en) last_en = cyc;
                    if (sq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL strobe_unexpected: got init=%0b en=%0b T=%0d, expected none",
                                 est_if.est_init, est_if.est_en, est_if.est_T);
                    end else begin
                        s = sq.pop_front();
                        check("strobe_kind", {est_if.est_init, est_if.est_en}, {s.init, !s.init});
                        check("strobe_T", est_if.est_T, s.t);
                    end
                end
                if (dT_upd) begin
                    if (uq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL upd_unexpected: got dT_out=%0d, expected no update", dT_out);
                    end else begin
                        e = uq.pop_front();
                        check("upd_dT_out", dT_out, e);
                        check("upd_latency", cyc - last_en, 2);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        t_valid   = 1'b0;
        t_in      = '0;
        period    = 16'd4;
        cfg_we    = 1'b0;
        cfg_alpha = '0;
        cfg_k     = '0;
        cfg_dmax  = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(1);
        check("rst_state", state, 0);
        check("rst_alpha", est_if.est_alpha, 32);
        check("rst_k", est_if.est_k, 3);
        check("rst_dmax", est_if.est_dmax, 64);
        check("rst_dT_out", dT_out, 0);
        check("rst_ready", dT_ready, 0);
        check("rst_fault", fault, 0);

        // Start-up: INIT then warm-up advances
        enable = 1'b1;
        step(2);
        stub_val = 8'sd5;
        push_s(1'b1, 8'sd10);
        iter(8'sd10);
        check("init_state", state, 2);
        repeat (3) begin
            push_s(1'b0, 8'sd10);
            iter(8'sd10);
        end
        check("warm3_ready", dT_ready, 0);
        check("warm3_state", state, 2);
        push_s(1'b0, 8'sd10);
        iter(8'sd10);
        check("warm4_state", state, 3);
        check("warm4_ready", dT_ready, 1);
        check("warm4_dT", dT_out, 5);

        // Published updates in RUN
        stub_val = 8'sd7;
        push_s(1'b0, 8'sd10);
        uq.push_back(8'sd7);
        iter(8'sd10);
        stub_val = 8'sd9;
        push_s(1'b0, 8'sd12);
        uq.push_back(8'sd9);
        iter(8'sd12);

        // Missing samples
        step(8);
        check("miss2_state", state, 3);
        step(4);
        check("fault_state", state, 4);
        check("fault_flag", fault, 1);
        check("fault_ready", dT_ready, 0);
        check("fault_dT_held", dT_out, 9);
        push_s(1'b1, -8'sd20);
        iter(-8'sd20);
        check("recover_state", state, 2);
        check("recover_fault", fault, 0);
        stub_val = 8'sd3;
        for (int i = 21; i <= 24; i++) begin
            push_s(1'b0, 8'(i));
            iter(8'(i));
        end
        check("rewarm_state", state, 3);
        check("rewarm_dT", dT_out, 3);

        // Config change at a sample boundary
        cfg_we    = 1'b1;
        cfg_alpha = 8'd128;
        cfg_k     = 8'd6;
        cfg_dmax  = 8'd10;
        t_valid   = 1'b1;
        t_in      = 8'sd40;
        step(1);
        cfg_we  = 1'b0;
        t_valid = 1'b0;
        check("cfg_alpha_held", est_if.est_alpha, 32);
        step(3);
        check("cfg_alpha", est_if.est_alpha, 128);
        check("cfg_k", est_if.est_k, 6);
        check("cfg_dmax", est_if.est_dmax, 10);
        check("cfg_state", state, 1);
        check("cfg_ready", dT_ready, 0);
        push_s(1'b1, 8'sd40);
        step(4);
        check("cfg_init_state", state, 2);

        // Sample coincident with the tick
        stub_val = 8'sd6;
        step(2);
        t_valid = 1'b1;
        t_in    = 8'sd33;
        push_s(1'b0, 8'sd33);
        step(1);
        t_valid = 1'b0;
        step(1);
        step(4);
        check("bypass_miss_state", state, 2);

        // period=0 ticks every clock, then enable drops mid-WARM
        period  = 16'd0;
        t_valid = 1'b1;
        t_in    = 8'sd1;
        push_s(1'b0, 8'sd1);
        step(1);
        t_in = 8'sd2;
        push_s(1'b0, 8'sd2);
        step(1);
        t_valid  = 1'b0;
        period   = 16'd4;
        enable   = 1'b0;
        stub_val = 8'sd99;
        step(1);
        check("dis_state", state, 0);
        check("dis_ready", dT_ready, 0);
        check("dis_dT_held", dT_out, 6);
        step(3);
        check("idle_state", state, 0);
        check("idle_alpha_kept", est_if.est_alpha, 128);

        // Back to RUN, then asynchronous reset between edges
        enable = 1'b1;
        step(2);
        stub_val = 8'sd2;
        push_s(1'b1, 8'sd50);
        iter(8'sd50);
        for (int i = 51; i <= 54; i++) begin
            push_s(1'b0, 8'(i));
            iter(8'(i));
        end
        check("rerun_state", state, 3);
        step(1);
        #2 rst = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_alpha", est_if.est_alpha, 32);
        check("arst_k", est_if.est_k, 3);
        check("arst_dmax", est_if.est_dmax, 64);
        check("arst_dT_out", dT_out, 0);
        check("arst_ready", dT_ready, 0);
        check("arst_fault", fault, 0);
        check("arst_T", est_if.est_T, 0);
        check("arst_strobes", {est_if.est_init, est_if.est_en, dT_upd}, 0);
        step(2);
        check("strobe_queue_empty", sq.size(), 0);
        check("upd_queue_empty", uq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
